mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares the single core memory port between the fetch stage's instruction requester and the load/store unit's data requester. Arbitrates each cycle, keeps the address phase stable until the memory grants, and tracks outstanding transactions in an ID queue so in-order responses (rvalid/rdata/err) are routed back to the requester that issued them. Sits between fetch/memory-access stages and the external req/gnt/rvalid bus.

## Interface
- MAX_OUTST, 2: max accepted-but-unanswered transactions (1..4)
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- instr_req_i  in  1  fetch request, held until instr_gnt_o
- instr_addr_i  in  32  fetch address
- instr_gnt_o  out  1  fetch address accepted this cycle
- instr_rvalid_o  out  1  fetch response valid
- instr_rdata_o  out  32  fetch response data (mem_rdata_i passthrough)
- instr_err_o  out  1  fetch response error
- data_req_i  in  1  load/store request, held until data_gnt_o
- data_we_i  in  1  1 = store
- data_be_i  in  4  byte enables
- data_addr_i  in  32  data address
- data_wdata_i  in  32  store data
- data_gnt_o  out  1  data address accepted this cycle
- data_rvalid_o  out  1  data response valid
- data_rdata_o  out  32  data response data (passthrough)
- data_err_o  out  1  data response error
- mem_req_o  out  1  bus request
- mem_we_o  out  1  bus write (0 for fetch)
- mem_be_o  out  4  bus byte enables (4'hF for fetch)
- mem_addr_o  out  32  bus address
- mem_wdata_o  out  32  bus write data (0 for fetch)
- mem_gnt_i  in  1  bus accepted address phase
- mem_rvalid_i  in  1  bus response valid, in issue order
- mem_rdata_i  in  32  bus response data
- mem_err_i  in  1  bus response error
- spurious_o  out  1  one-cycle pulse: rvalid with no outstanding transaction

## Operation
- States: IDLE, WAIT_I, WAIT_D. IDLE: pick owner combinationally; if mem_req_o=1 and mem_gnt_i=0, register owner → WAIT_I/WAIT_D. WAIT_x: owner forced, other requester ignored; on mem_gnt_i → IDLE.
- Owner choice in IDLE: single requester wins. Both: winner opposite of last_contest (1 bit, reset = instr, so first contest goes to data); last_contest updates only on contested cycles.
- mem_req_o = (owner requesting) & ~queue_full. Queue full blocks issue even if mem_rvalid_i same cycle (no bypass).
- Bus fields muxed from owner; fetch drives we=0, be=4'hF, wdata=0.
- instr_gnt_o / data_gnt_o = mem_gnt_i & mem_req_o & owner match; never both.
- ID queue: MAX_OUTST-entry FIFO of 1-bit requester ID + count (0..MAX_OUTST). Push on granted request, pop on mem_rvalid_i. Push and pop same cycle: count unchanged, head advances.
- Response routing: head ID selects instr_rvalid_o or data_rvalid_o = mem_rvalid_i; err likewise gated. rdata passes to both unconditionally.
- mem_rvalid_i with count=0: no rvalid to either side, spurious_o=1, no pointer change.
- Requester dropping req before gnt is a protocol violation; behaviour undefined, not checked.

## Timing
- Reset values: state IDLE, count 0, pointers 0, last_contest=instr; all outputs 0 except passthrough rdata; mem_be_o 0 while mem_req_o=0.
- Grant is zero-latency: gnt outputs combinational from mem_gnt_i in the same cycle.
- Response is zero-latency passthrough; earliest response is cycle after grant.
- Throughput: one grant per cycle while count < MAX_OUTST.
- Reset mid-operation: queue cleared; later responses for pre-reset transactions produce spurious_o, not routed.

## Test plan
- Fetch only, mem_gnt_i=1 always, rvalid 1 cycle later, addr 0x0,0x4,0x8 → 3 instr_gnt_o, 3 instr_rvalid_o with matching rdata, data_rvalid_o never 1.
- Both request from reset, gnt=1 → data granted first, then instr, then data (alternation); mem_we_o/mem_be_o follow owner each cycle.
- Fetch requests, mem_gnt_i=0 for 3 cycles while data_req_i rises → mem_addr_o stays fetch addr, data_gnt_o=0 until fetch granted, data granted next cycle.
- MAX_OUTST=2, grant 2 without rvalid → mem_req_o=0 on 3rd; rvalid and pending request same cycle → still blocked that cycle, granted next.
- Mixed issue order D,I,D then 3 rvalids with err on 2nd → data_rvalid, instr_rvalid+instr_err_o=1, data_rvalid.
- rvalid with count=0, and rst asserted with 1 outstanding then rvalid → spurious_o=1 one cycle each, no rvalid outputs.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - fetch, load/store and memory-bus signals of the port arbiter
// master is the arbiter's view; slave is the surrounding stages and the bus.
interface mem_port_arbiter_if;
  logic        instr_req_i;
  logic [31:0] instr_addr_i;
  logic        instr_gnt_o;
  logic        instr_rvalid_o;
  logic [31:0] instr_rdata_o;
  logic        instr_err_o;

  logic        data_req_i;
  logic        data_we_i;
  logic [3:0]  data_be_i;
  logic [31:0] data_addr_i;
  logic [31:0] data_wdata_i;
  logic        data_gnt_o;
  logic        data_rvalid_o;
  logic [31:0] data_rdata_o;
  logic        data_err_o;

  logic        mem_req_o;
  logic        mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        mem_gnt_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic        mem_err_i;

  logic        spurious_o;

  modport master (
    input  instr_req_i, instr_addr_i,
    output instr_gnt_o, instr_rvalid_o, instr_rdata_o, instr_err_o,
    input  data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
    output data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o,
    output mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
    input  mem_gnt_i, mem_rvalid_i, mem_rdata_i, mem_err_i,
    output spurious_o
  );

  modport slave (
    output instr_req_i, instr_addr_i,
    input  instr_gnt_o, instr_rvalid_o, instr_rdata_o, instr_err_o,
    output data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
    input  data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o,
    input  mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
    output mem_gnt_i, mem_rvalid_i, mem_rdata_i, mem_err_i,
    input  spurious_o
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one memory port between fetch and load/store
// Address phase is locked to its owner until granted; an ID FIFO routes in-order responses.
module mem_port_arbiter #(
  parameter int MAX_OUTST = 2
) (
  input  logic                clk,
  input  logic                rst,
  mem_port_arbiter_if.master  bus
);

  localparam int PW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  localparam int CW = $clog2(MAX_OUTST + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(MAX_OUTST);
  localparam logic [PW-1:0] LAST_PTR = PW'(MAX_OUTST - 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] WAIT_I = 2'd1;
  localparam logic [1:0] WAIT_D = 2'd2;

  localparam logic ID_INSTR = 1'b0;
  localparam logic ID_DATA  = 1'b1;

  logic [1:0]          state;
  logic                last_contest;
  logic                owner;
  logic                owner_req;
  logic                contested;
  logic                queue_full;
  logic                queue_empty;
  logic                issue;
  logic                grant;
  logic                pop;
  logic                head_id;
  logic [MAX_OUTST-1:0] id_q;
  logic [PW-1:0]       wptr;
  logic [PW-1:0]       rptr;
  logic [CW-1:0]       count;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    if (p == LAST_PTR) begin
      next_ptr = '0;
    end else begin
      next_ptr = p + PW'(1);
    end
  endfunction

  always_comb begin
    contested = (state == IDLE) && bus.instr_req_i && bus.data_req_i;
    owner     = ID_INSTR;
    case (state)
      WAIT_I:  owner = ID_INSTR;
      WAIT_D:  owner = ID_DATA;
      default: begin
        if (contested) begin
          owner = ~last_contest;
        end else if (bus.data_req_i && !bus.instr_req_i) begin
          owner = ID_DATA;
        end else begin
          owner = ID_INSTR;
        end
      end
    endcase
  end

  // No bypass: a full queue blocks issue even when a response frees a slot this cycle.
  assign owner_req   = (owner == ID_DATA) ? bus.data_req_i : bus.instr_req_i;
  assign queue_full  = (count == FULL_CNT);
  assign queue_empty = (count == '0);
  assign issue       = owner_req && !queue_full;
  assign grant       = issue && bus.mem_gnt_i;
  assign pop         = bus.mem_rvalid_i && !queue_empty;
  assign head_id     = id_q[rptr];

  always_comb begin
    bus.mem_req_o   = issue;
    bus.mem_we_o    = 1'b0;
    bus.mem_be_o    = 4'h0;
    bus.mem_addr_o  = 32'h0;
    bus.mem_wdata_o = 32'h0;
    if (issue) begin
      if (owner == ID_DATA) begin
        bus.mem_we_o    = bus.data_we_i;
        bus.mem_be_o    = bus.data_be_i;
        bus.mem_addr_o  = bus.data_addr_i;
        bus.mem_wdata_o = bus.data_wdata_i;
      end else begin
        bus.mem_be_o    = 4'hF;
        bus.mem_addr_o  = bus.instr_addr_i;
      end
    end
  end

  assign bus.instr_gnt_o    = grant && (owner == ID_INSTR);
  assign bus.data_gnt_o     = grant && (owner == ID_DATA);
  assign bus.instr_rvalid_o = pop && (head_id == ID_INSTR);
  assign bus.data_rvalid_o  = pop && (head_id == ID_DATA);
  assign bus.instr_err_o    = pop && (head_id == ID_INSTR) && bus.mem_err_i;
  assign bus.data_err_o     = pop && (head_id == ID_DATA) && bus.mem_err_i;
  assign bus.instr_rdata_o  = bus.mem_rdata_i;
  assign bus.data_rdata_o   = bus.mem_rdata_i;
  assign bus.spurious_o     = bus.mem_rvalid_i && queue_empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      last_contest <= ID_INSTR;
    end else begin
      if (contested && issue) begin
        last_contest <= owner;
      end
      case (state)
        IDLE: begin
          if (issue && !bus.mem_gnt_i) begin
            state <= (owner == ID_DATA) ? WAIT_D : WAIT_I;
          end
        end
        WAIT_I, WAIT_D: begin
          if (grant) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id_q  <= '0;
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (grant) begin
        id_q[wptr] <= owner;
        wptr       <= next_ptr(wptr);
      end
      if (pop) begin
        rptr <= next_ptr(rptr);
      end
      case ({grant, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed stimulus with a queue-based reference model
module tb_mem_port_arbiter;
  localparam int MAXO = 2;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;
  bit   cmp_en;

  mem_port_arbiter_if bif ();

  mem_port_arbiter #(.MAX_OUTST(MAXO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: owner lock, contest history and a queue of issuer IDs (0=instr, 1=data)
  int          m_lock;
  bit          m_last;
  bit          m_ids[$];
  int          own;
  bit          oreq;
  bit          e_req;
  bit          e_we;
  logic [3:0]  e_be;
  logic [31:0] e_addr;
  logic [31:0] e_wd;
  bit          e_ig, e_dg, e_irv, e_drv, e_ie, e_de, e_sp;

  initial begin
    m_lock = -1;
    m_last = 1'b0;
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      if (rst) begin
        m_ids.delete();
        m_lock = -1;
        m_last = 1'b0;
      end
      if (m_lock >= 0) own = m_lock;
      else if (bif.instr_req_i && bif.data_req_i) own = m_last ? 0 : 1;
      else if (bif.instr_req_i) own = 0;
      else if (bif.data_req_i) own = 1;
      else own = -1;
      oreq  = (own == 0) ? bif.instr_req_i : (own == 1) ? bif.data_req_i : 1'b0;
      e_req = oreq && (m_ids.size() < MAXO);
      e_we = 1'b0; e_be = 4'h0; e_addr = 32'h0; e_wd = 32'h0;
      if (e_req && own == 1) begin
        e_we = bif.data_we_i; e_be = bif.data_be_i;
        e_addr = bif.data_addr_i; e_wd = bif.data_wdata_i;
      end else if (e_req) begin
        e_be = 4'hF; e_addr = bif.instr_addr_i;
      end
      e_ig = bif.mem_gnt_i && e_req && own == 0;
      e_dg = bif.mem_gnt_i && e_req && own == 1;
      e_irv = 0; e_drv = 0; e_ie = 0; e_de = 0; e_sp = 0;
      if (bif.mem_rvalid_i && m_ids.size() == 0) e_sp = 1;
      else if (bif.mem_rvalid_i) begin
        if (m_ids[0]) begin e_drv = 1; e_de = bif.mem_err_i; end
        else begin e_irv = 1; e_ie = bif.mem_err_i; end
      end
      check("mem_req", 32'(bif.mem_req_o), 32'(e_req));
      check("mem_we", 32'(bif.mem_we_o), 32'(e_we));
      check("mem_be", 32'(bif.mem_be_o), 32'(e_be));
      check("mem_addr", bif.mem_addr_o, e_addr);
      check("mem_wdata", bif.mem_wdata_o, e_wd);
      check("instr_gnt", 32'(bif.instr_gnt_o), 32'(e_ig));
      check("data_gnt", 32'(bif.data_gnt_o), 32'(e_dg));
      check("instr_rvalid", 32'(bif.instr_rvalid_o), 32'(e_irv));
      check("data_rvalid", 32'(bif.data_rvalid_o), 32'(e_drv));
      check("instr_err", 32'(bif.instr_err_o), 32'(e_ie));
      check("data_err", 32'(bif.data_err_o), 32'(e_de));
      check("instr_rdata", bif.instr_rdata_o, bif.mem_rdata_i);
      check("data_rdata", bif.data_rdata_o, bif.mem_rdata_i);
      check("spurious", 32'(bif.spurious_o), 32'(e_sp));
      if (!rst) begin
        if (m_lock < 0 && bif.instr_req_i && bif.data_req_i && e_req) m_last = (own == 1);
        if (e_req && !bif.mem_gnt_i && m_lock < 0) m_lock = own;
        else if (e_req && bif.mem_gnt_i) m_lock = -1;
        if (bif.mem_rvalid_i && m_ids.size() > 0) void'(m_ids.pop_front());
        if (e_req && bif.mem_gnt_i) m_ids.push_back(own == 1);
      end
    end
  end

  task automatic set(input bit ireq, input logic [31:0] iaddr, input bit dreq, input bit dwe,
                     input logic [3:0] dbe, input logic [31:0] daddr, input logic [31:0] dwd,
                     input bit gnt, input bit rv, input logic [31:0] rd, input bit er);
    @(posedge clk);
    #1;
    bif.instr_req_i  = ireq;  bif.instr_addr_i = iaddr;
    bif.data_req_i   = dreq;  bif.data_we_i    = dwe;
    bif.data_be_i    = dbe;   bif.data_addr_i  = daddr;
    bif.data_wdata_i = dwd;   bif.mem_gnt_i    = gnt;
    bif.mem_rvalid_i = rv;    bif.mem_rdata_i  = rd;
    bif.mem_err_i    = er;
  endtask

  task automatic idle();
    set(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    bif.instr_req_i = 0; bif.data_req_i = 0; bif.mem_gnt_i = 0;
    bif.mem_rvalid_i = 0; bif.mem_err_i = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1;
    bif.instr_req_i = 0; bif.instr_addr_i = 0;
    bif.data_req_i = 0; bif.data_we_i = 0; bif.data_be_i = 0;
    bif.data_addr_i = 0; bif.data_wdata_i = 0;
    bif.mem_gnt_i = 0; bif.mem_rvalid_i = 0; bif.mem_rdata_i = 0; bif.mem_err_i = 0;
    cmp_en = 1'b1;
    settle();
    check("reset mem_req", 32'(bif.mem_req_o), 32'h0);
    check("reset mem_be", 32'(bif.mem_be_o), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // fetch only, back-to-back grants, responses one cycle later
    set(1, 32'h0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    settle(); check("t1 gnt0", 32'(bif.instr_gnt_o), 32'h1);
    check("t1 be", 32'(bif.mem_be_o), 32'hF);
    set(1, 32'h4, 0, 0, 0, 0, 0, 1, 1, 32'h1000, 0);
    settle(); check("t1 rv0", 32'(bif.instr_rvalid_o), 32'h1);
    check("t1 addr1", bif.mem_addr_o, 32'h4);
    set(1, 32'h8, 0, 0, 0, 0, 0, 1, 1, 32'h1004, 0);
    set(0, 0, 0, 0, 0, 0, 0, 1, 1, 32'h1008, 0);
    settle(); check("t1 rv2 rdata", bif.instr_rdata_o, 32'h1008);
    check("t1 no drv", 32'(bif.data_rvalid_o), 32'h0);
    idle();

    // contention from reset alternates data, instr, data
    do_reset();
    set(1, 32'h100, 1, 1, 4'h3, 32'h200, 32'hAA, 1, 0, 0, 0);
    settle(); check("t2 data first", 32'(bif.data_gnt_o), 32'h1);
    check("t2 we", 32'(bif.mem_we_o), 32'h1);
    check("t2 be", 32'(bif.mem_be_o), 32'h3);
    set(1, 32'h100, 1, 0, 4'hF, 32'h204, 0, 1, 1, 32'h2000, 0);
    settle(); check("t2 instr second", 32'(bif.instr_gnt_o), 32'h1);
    check("t2 we0", 32'(bif.mem_we_o), 32'h0);
    set(1, 32'h104, 1, 0, 4'hF, 32'h204, 0, 1, 1, 32'h2004, 0);
    settle(); check("t2 data third", 32'(bif.data_gnt_o), 32'h1);
    check("t2 addr3", bif.mem_addr_o, 32'h204);
    set(1, 32'h104, 0, 0, 0, 0, 0, 1, 1, 32'h2008, 0);
    set(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h200C, 0);
    idle();

    // fetch stalled by the bus while data request arrives
    set(1, 32'h300, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    set(1, 32'h300, 1, 1, 4'hF, 32'h400, 32'h55, 0, 0, 0, 0);
    settle(); check("t3 addr held", bif.mem_addr_o, 32'h300);
    check("t3 no dgnt", 32'(bif.data_gnt_o), 32'h0);
    set(1, 32'h300, 1, 1, 4'hF, 32'h400, 32'h55, 0, 0, 0, 0);
    set(1, 32'h300, 1, 1, 4'hF, 32'h400, 32'h55, 1, 0, 0, 0);
    settle(); check("t3 igrant", 32'(bif.instr_gnt_o), 32'h1);
    set(0, 0, 1, 1, 4'hF, 32'h400, 32'h55, 1, 1, 32'h3000, 0);
    settle(); check("t3 dgrant", 32'(bif.data_gnt_o), 32'h1);
    set(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h3004, 0);
    idle();

    // outstanding limit blocks issue, no bypass on a same-cycle response
    set(1, 32'h500, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    set(1, 32'h504, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    set(1, 32'h508, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    settle(); check("t4 full blocks", 32'(bif.mem_req_o), 32'h0);
    set(1, 32'h508, 0, 0, 0, 0, 0, 1, 1, 32'h5000, 0);
    settle(); check("t4 no bypass", 32'(bif.mem_req_o), 32'h0);
    set(1, 32'h508, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    settle(); check("t4 granted", 32'(bif.instr_gnt_o), 32'h1);
    set(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h5004, 0);
    set(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h5008, 0);
    idle();

    // issue D, I, D; error on the instr response is routed to fetch only
    set(0, 0, 1, 0, 4'hF, 32'h600, 0, 1, 0, 0, 0);
    set(1, 32'h700, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    set(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h6000, 0);
    settle(); check("t5 drv1", 32'(bif.data_rvalid_o), 32'h1);
    set(0, 0, 1, 1, 4'hC, 32'h604, 32'h77, 1, 1, 32'h7000, 1);
    settle(); check("t5 ierr", 32'(bif.instr_err_o), 32'h1);
    check("t5 no derr", 32'(bif.data_err_o), 32'h0);
    set(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h6004, 0);
    settle(); check("t5 drv3", 32'(bif.data_rvalid_o), 32'h1);
    idle();

    // spurious response, then reset drops an outstanding transaction
    set(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hDEAD, 0);
    settle(); check("t6 spurious", 32'(bif.spurious_o), 32'h1);
    idle();
    settle(); check("t6 pulse ends", 32'(bif.spurious_o), 32'h0);
    set(1, 32'h800, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    do_reset();
    set(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hBEEF, 0);
    settle(); check("t6 post-reset spurious", 32'(bif.spurious_o), 32'h1);
    check("t6 not routed", 32'(bif.instr_rvalid_o), 32'h0);
    idle();
    idle();

    @(posedge clk);
    cmp_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
